// File: rtl/lsu_access_sequencer.sv
// lsu_access_sequencer: runs each pipeline load/store as one or two word accesses
// on a single-ported data memory and returns the lane-extracted, extended result.
// Build option: define LSU_MISALIGN_SPLIT_EN to let accesses that straddle a word
// boundary run as two memory beats; without it such accesses end with resp_err_o.
//
// state | meaning
// IDLE  | waiting for a request, req_ready_o high
// ACC0  | first (or only) memory beat at the aligned word address
// ACC1  | second beat at aligned address + 4 (split build only)
// RESP  | one-cycle completion pulse with load result or error
module lsu_access_sequencer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [2:0]    req_func3_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          mem_valid_o,
  input  logic          mem_ready_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_mask_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          resp_valid_o,
  output logic [DW-1:0] resp_rdata_o,
  output logic          resp_err_o,
  output logic          busy_o
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC0 = 2'd1, S_RESP = 2'd2, S_ACC1 = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC0 = 2'd1, S_RESP = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [2:0]      func3_q, func3_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   lo_q, lo_d;

  // Zero mask marks an illegal func3 encoding.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_mask = 4'b0001;
      3'b001, 3'b101: size_mask = 4'b0011;
      3'b010:         size_mask = 4'b1111;
      default:        size_mask = 4'b0000;
    endcase
  endfunction

  logic [3:0]    smask_req;
  logic [3:0]    smask;
  logic [4:0]    sh_amt;
  logic [AW-1:0] addr_al;
  logic [DW-1:0] r;
  logic [DW-1:0] ext;

  assign smask_req = size_mask(req_func3_i);
  assign smask     = size_mask(func3_q);
  assign sh_amt    = {addr_q[1:0], 3'b000};
  assign addr_al   = {addr_q[AW-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DW-1:0]   hi_q, hi_d;
  logic [7:0]      lanes;
  logic [2*DW-1:0] wd_sh;
  logic            split;

  assign lanes = {4'b0000, smask} << addr_q[1:0];
  assign wd_sh = {{DW{1'b0}}, wdata_q} << sh_amt;
  assign split = |lanes[7:4];
  assign r     = DW'({hi_q, lo_q} >> sh_amt);
`else
  logic [7:0]    lanes_req;
  logic          split_req;
  logic [3:0]    lanes;
  logic [DW-1:0] wd_sh;

  assign lanes_req = {4'b0000, smask_req} << req_addr_i[1:0];
  assign split_req = |lanes_req[7:4];
  assign lanes     = smask << addr_q[1:0];
  assign wd_sh     = wdata_q << sh_amt;
  assign r         = lo_q >> sh_amt;
`endif

  // Extend the selected bytes according to the load type.
  always_comb begin
    case (func3_q)
      3'b000:  ext = {{(DW-8){r[7]}}, r[7:0]};
      3'b001:  ext = {{(DW-16){r[15]}}, r[15:0]};
      3'b100:  ext = {{(DW-8){1'b0}}, r[7:0]};
      3'b101:  ext = {{(DW-16){1'b0}}, r[15:0]};
      default: ext = r;
    endcase
  end

  // State and latched-request registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      func3_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      hi_q    <= hi_d;
`endif
    end
  end

  // Next-state and output decode; memory outputs depend only on registered state so they hold until mem_ready_i.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    err_d        = err_q;
    func3_d      = func3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    hi_d         = hi_q;
`endif
    req_ready_o  = 1'b0;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_mask_o   = 4'b0000;
    mem_wdata_o  = '0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          func3_d = req_func3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          err_d   = (smask_req == 4'b0000);
`ifndef LSU_MISALIGN_SPLIT_EN
          if (split_req) err_d = 1'b1;
`endif
          state_d = err_d ? S_RESP : S_ACC0;
        end
      end
      S_ACC0: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_al;
        mem_mask_o  = lanes[3:0];
        mem_wdata_o = wd_sh[DW-1:0];
        if (mem_ready_i) begin
          lo_d = mem_rdata_i;
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = split ? S_ACC1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACC1: begin
        mem_valid_o = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_al + AW'(4);
        mem_mask_o  = lanes[7:4];
        mem_wdata_o = wd_sh[2*DW-1:DW];
        if (mem_ready_i) begin
          hi_d    = mem_rdata_i;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        if (!err_q && !we_q) resp_rdata_o = ext;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Scoreboard bench for lsu_access_sequencer: stimulus queues expected memory beats and
// responses; a negedge monitor compares whatever the DUT presents.
module tb_lsu_access_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [2:0]  req_func3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_mask_o;
  logic        resp_valid_o, resp_err_o, busy_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] rd_lo, rd_hi;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; } mem_t;
  resp_t resp_q[$];
  mem_t  mem_q[$];

  lsu_access_sequencer #(.AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_func3_i(req_func3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_mask_o(mem_mask_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  assign mem_rdata_i = (mem_addr_o == 32'h0000_0304) ? rd_hi : rd_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every memory beat and every response against the queues.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_valid_o) begin
        if (mem_q.size() == 0) chk("unexpected_mem_valid", 32'(mem_valid_o), 32'd0);
        else begin
          chk("mem_we",    32'(mem_we_o),   32'(mem_q[0].we));
          chk("mem_addr",  mem_addr_o,      mem_q[0].addr);
          chk("mem_mask",  32'(mem_mask_o), 32'(mem_q[0].mask));
          chk("mem_wdata", mem_wdata_o,     mem_q[0].wdata);
          if (mem_ready_i) void'(mem_q.pop_front());
        end
      end
      if (resp_valid_o) begin
        if (resp_q.size() == 0) chk("unexpected_resp_valid", 32'(resp_valid_o), 32'd0);
        else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_err",   32'(resp_err_o), 32'(e.err));
          chk("resp_rdata", resp_rdata_o,    e.rdata);
          chk("resp_cycle", cyc,             e.cyc);
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wd);
    mem_q.push_back('{we, addr, mask, wd});
  endtask

  // lat <= 0 means no response is expected (transaction will be aborted).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic eerr, input logic [31:0] erd,
                       input int lat);
    @(posedge clk_i); #1;
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_func3_i = f3; req_addr_i = addr; req_wdata_i = wd;
    if (lat > 0) resp_q.push_back('{eerr, erd, cyc + lat});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_wdata_i = 32'h0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (resp_q.size() == 0) break;
      @(negedge clk_i);
    end
    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("mem_queue_drained",  mem_q.size(),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_func3_i = 3'b000;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; mem_ready_i = 1'b1;
    rd_lo = 32'h0; rd_hi = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready",  32'(req_ready_o),  32'd1);
    chk("rst_mem_valid",  32'(mem_valid_o),  32'd0);
    chk("rst_busy",       32'(busy_o),       32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("idle_resp_rdata", resp_rdata_o,      32'd0);
    chk("idle_mem_addr",   mem_addr_o,        32'd0);
    chk("idle_mem_mask",   32'(mem_mask_o),   32'd0);

    // sw aligned
    push_mem(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 2); drain();
    // lb / lbu at offset 3
    rd_lo = 32'h80FF_0000;
    push_mem(1'b0, 32'h100, 4'b1000, 32'h0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 2); drain();
    push_mem(1'b0, 32'h100, 4'b1000, 32'h0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h00000080, 2); drain();
    // lh / lhu at offset 2
    rd_lo = 32'h8001_1234;
    push_mem(1'b0, 32'h104, 4'b1100, 32'h0);
    issue(1'b0, 3'b001, 32'h106, 32'h0, 1'b0, 32'hFFFF8001, 2); drain();
    push_mem(1'b0, 32'h104, 4'b1100, 32'h0);
    issue(1'b0, 3'b101, 32'h106, 32'h0, 1'b0, 32'h00008001, 2); drain();
    // sh at offset 2, sb at offset 1
    push_mem(1'b1, 32'h200, 4'b1100, 32'hABCD0000);
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1'b0, 32'h0, 2); drain();
    push_mem(1'b1, 32'h100, 4'b0010, 32'h0000A500);
    issue(1'b1, 3'b000, 32'h101, 32'h000000A5, 1'b0, 32'h0, 2); drain();

    // straddling accesses
`ifdef LSU_MISALIGN_SPLIT_EN
    rd_lo = 32'h44332211; rd_hi = 32'h00000055;
    push_mem(1'b0, 32'h300, 4'b1110, 32'h0);
    push_mem(1'b0, 32'h304, 4'b0001, 32'h0);
    issue(1'b0, 3'b010, 32'h301, 32'h0, 1'b0, 32'h55443322, 3); drain();
    rd_lo = 32'hAB0000CD;
    push_mem(1'b0, 32'hFFFFFFFC, 4'b1000, 32'h0);
    push_mem(1'b0, 32'h00000000, 4'b0001, 32'h0);
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b0, 32'hFFFFCDAB, 3); drain();
    push_mem(1'b1, 32'h100, 4'b1000, 32'h44000000);
    push_mem(1'b1, 32'h104, 4'b0111, 32'h00112233);
    issue(1'b1, 3'b010, 32'h103, 32'h11223344, 1'b0, 32'h0, 3); drain();
`else
    issue(1'b0, 3'b010, 32'h301, 32'h0, 1'b1, 32'h0, 1); drain();
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1); drain();
    issue(1'b1, 3'b010, 32'h103, 32'h11223344, 1'b1, 32'h0, 1); drain();
`endif

    // memory stall of 3 cycles in ACC0 with ignored request pulses
    rd_lo = 32'hCAFEF00D; mem_ready_i = 1'b0;
    push_mem(1'b0, 32'h400, 4'b1111, 32'h0);
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 32'hCAFEF00D, 5);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h500; req_wdata_i = 32'h5555;
    @(negedge clk_i);
    chk("stall_busy",      32'(busy_o),      32'd1);
    chk("stall_req_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    @(posedge clk_i); #1 req_valid_i = 1'b1;
    @(posedge clk_i); #1 req_valid_i = 1'b0; mem_ready_i = 1'b1;
    drain();

    // illegal func3 encodings
    issue(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0, 1); drain();
    issue(1'b0, 3'b110, 32'h100, 32'h0, 1'b1, 32'h0, 1); drain();
    issue(1'b1, 3'b111, 32'h100, 32'hFFFF, 1'b1, 32'h0, 1); drain();

    // reset while a memory beat is outstanding
`ifdef LSU_MISALIGN_SPLIT_EN
    rd_lo = 32'h44332211; rd_hi = 32'h00000055;
    push_mem(1'b0, 32'h300, 4'b1110, 32'h0);
    push_mem(1'b0, 32'h304, 4'b0001, 32'h0);
    issue(1'b0, 3'b010, 32'h301, 32'h0, 1'b0, 32'h0, 0);
    @(posedge clk_i); #1 mem_ready_i = 1'b0;
`else
    mem_ready_i = 1'b0;
    push_mem(1'b0, 32'h400, 4'b1111, 32'h0);
    issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 32'h0, 0);
`endif
    @(negedge clk_i); #1;
    chk("abort_mem_valid_before", 32'(mem_valid_o), 32'd1);
    rst_i = 1'b1; #1;
    chk("abort_mem_valid_async", 32'(mem_valid_o), 32'd0);
    chk("abort_busy",            32'(busy_o),      32'd0);
    chk("abort_req_ready",       32'(req_ready_o), 32'd1);
    mem_q.delete(); resp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0; mem_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // recovery after abort
    push_mem(1'b1, 32'h100, 4'b1111, 32'h01020304);
    issue(1'b1, 3'b010, 32'h100, 32'h01020304, 1'b0, 32'h0, 2); drain();
    repeat (3) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
